// File: rtl/semaphore_monitor.sv
// Receiving-end checker for the two-road semaphore lamp bus: decodes the lamps,
// follows normal cycling and flash mode, checks order and dwell, latches the first fault.
module semaphore_monitor #(
  parameter int GREEN_MIN    = 3,
  parameter int GREEN_MAX    = 8,
  parameter int YELLOW_TICKS = 1,
  parameter int FLASH_HALF   = 1,
  parameter int DW           = 16
) (
  input  logic          clk,
  input  logic          res,
  input  logic          r,
  input  logic          g,
  input  logic          v,
  input  logic          r1,
  input  logic          g1,
  input  logic          v1,
  output logic [2:0]    phase,
  output logic          locked,
  output logic          flashing,
  output logic          err,
  output logic [2:0]    err_code,
  output logic [DW-1:0] cycles
);

  typedef enum logic [1:0] {S_SYNC, S_RUN, S_FLASH, S_ERR} state_t;

  localparam logic [2:0] P_A = 3'd1, P_AY = 3'd2, P_B = 3'd3, P_BY = 3'd4;
  localparam logic [2:0] FL_ON = 3'd5, FL_OFF = 3'd6, ILLEGAL = 3'd7;

  localparam logic [DW:0] L_GMIN = (DW+1)'(GREEN_MIN);
  localparam logic [DW:0] L_GMAX = (DW+1)'(GREEN_MAX);
  localparam logic [DW:0] L_YEL  = (DW+1)'(YELLOW_TICKS);
  localparam logic [DW:0] L_FL   = (DW+1)'(FLASH_HALF);

  state_t          state_reg, state_next;
  logic [2:0]      phase_reg, prev_reg, code_reg, code_next, sample;
  logic [DW-1:0]   dwell_reg, dwell_next, cycles_reg, cycles_next;
  logic            first_reg, first_next, err_reg, err_next;
  logic            locked_reg, flashing_reg;

  logic            same, is_green, is_yellow, is_flash, succ_ok, skip_dwell;
  logic            f_ill, f_succ, f_short, f_long, run_like;
  logic [DW:0]     dwell_ext, dwell_plus, max_limit, min_limit;
  logic [2:0]      fault;

  always_comb begin
    case ({r, g, v, r1, g1, v1})
      6'b100_001: sample = P_A;
      6'b100_010: sample = P_AY;
      6'b001_100: sample = P_B;
      6'b010_100: sample = P_BY;
      6'b010_010: sample = FL_ON;
      6'b000_000: sample = FL_OFF;
      default:    sample = ILLEGAL;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    first_next  = first_reg;
    cycles_next = cycles_reg;
    err_next    = err_reg;
    code_next   = code_reg;

    same       = (sample == prev_reg);
    is_green   = (prev_reg == P_A)   || (prev_reg == P_B);
    is_yellow  = (prev_reg == P_AY)  || (prev_reg == P_BY);
    is_flash   = (prev_reg == FL_ON) || (prev_reg == FL_OFF);
    dwell_ext  = {1'b0, dwell_reg};
    dwell_plus = dwell_ext + 1'b1;

    if (same)
      dwell_next = (dwell_reg == '1) ? dwell_reg : dwell_reg + 1'b1;
    else
      dwell_next = DW'(1);

    max_limit = '1;
    min_limit = '0;
    if (is_green) begin
      max_limit = L_GMAX;
      min_limit = L_GMIN;
    end else if (is_yellow) begin
      max_limit = L_YEL;
      min_limit = L_YEL;
    end else if (is_flash) begin
      max_limit = L_FL;
      min_limit = L_FL;
    end

    // Legal successors depend on the mode; leaving flash for P_A is the mode exit
    succ_ok    = 1'b0;
    skip_dwell = 1'b0;
    if (state_reg == S_RUN) begin
      succ_ok = (sample == FL_ON) ||
                (prev_reg == P_A  && sample == P_AY) ||
                (prev_reg == P_AY && sample == P_B)  ||
                (prev_reg == P_B  && sample == P_BY) ||
                (prev_reg == P_BY && sample == P_A);
    end else if (state_reg == S_FLASH) begin
      skip_dwell = (sample == P_A);
      succ_ok = skip_dwell ||
                (prev_reg == FL_ON  && sample == FL_OFF) ||
                (prev_reg == FL_OFF && sample == FL_ON);
    end

    run_like = (state_reg == S_RUN) || (state_reg == S_FLASH);
    f_ill    = run_like && (sample == ILLEGAL);
    f_succ   = run_like && !same && !succ_ok;
    f_short  = run_like && !same && !skip_dwell && !first_reg && (dwell_ext < min_limit);
    f_long   = run_like && ((!same && !skip_dwell && !is_green && (dwell_ext > max_limit)) ||
                            (same && (dwell_plus > max_limit)));

    if (f_ill)        fault = 3'd1;
    else if (f_succ)  fault = 3'd2;
    else if (f_short) fault = 3'd3;
    else if (f_long)  fault = 3'd4;
    else              fault = 3'd0;

    case (state_reg)
      S_SYNC: begin
        if (sample == P_A || sample == FL_ON) begin
          state_next = (sample == P_A) ? S_RUN : S_FLASH;
          first_next = 1'b1;
          dwell_next = DW'(1);
        end
      end
      S_RUN, S_FLASH: begin
        if (fault != 3'd0) begin
          state_next = S_ERR;
          err_next   = 1'b1;
          code_next  = fault;
        end else if (!same) begin
          first_next = 1'b0;
          if (state_reg == S_RUN && sample == FL_ON) begin
            state_next = S_FLASH;
            first_next = 1'b1;
          end else if (state_reg == S_FLASH && sample == P_A) begin
            state_next = S_RUN;
            first_next = 1'b1;
          end
          if (state_reg == S_RUN && prev_reg == P_BY && sample == P_A)
            cycles_next = cycles_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg    <= S_SYNC;
      phase_reg    <= '0;
      prev_reg     <= '0;
      dwell_reg    <= '0;
      first_reg    <= 1'b0;
      err_reg      <= 1'b0;
      code_reg     <= '0;
      cycles_reg   <= '0;
      locked_reg   <= 1'b0;
      flashing_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= sample;
      prev_reg     <= sample;
      dwell_reg    <= dwell_next;
      first_reg    <= first_next;
      err_reg      <= err_next;
      code_reg     <= code_next;
      cycles_reg   <= cycles_next;
      locked_reg   <= (state_next == S_RUN) || (state_next == S_FLASH);
      flashing_reg <= (state_next == S_FLASH);
    end
  end

  assign phase    = phase_reg;
  assign locked   = locked_reg;
  assign flashing = flashing_reg;
  assign err      = err_reg;
  assign err_code = code_reg;
  assign cycles   = cycles_reg;

endmodule

// File: tb/tb_semaphore_monitor.sv
// Directed bench for semaphore_monitor: lamp patterns in, phase/lock/fault outputs checked.
module tb_semaphore_monitor;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        r = 1'b0, g = 1'b0, v = 1'b0, r1 = 1'b0, g1 = 1'b0, v1 = 1'b0;
  logic [2:0]  phase;
  logic        locked, flashing, err;
  logic [2:0]  err_code;
  logic [15:0] cycles;

  int tests = 0;
  int fails = 0;

  semaphore_monitor dut (
    .clk(clk), .res(res),
    .r(r), .g(g), .v(v), .r1(r1), .g1(g1), .v1(v1),
    .phase(phase), .locked(locked), .flashing(flashing),
    .err(err), .err_code(err_code), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Drive one lamp pattern for one sample; outputs are valid on return
  task automatic step(input int p);
    case (p)
      1: {r, g, v, r1, g1, v1} = 6'b100_001;
      2: {r, g, v, r1, g1, v1} = 6'b100_010;
      3: {r, g, v, r1, g1, v1} = 6'b001_100;
      4: {r, g, v, r1, g1, v1} = 6'b010_100;
      5: {r, g, v, r1, g1, v1} = 6'b010_010;
      6: {r, g, v, r1, g1, v1} = 6'b000_000;
      default: {r, g, v, r1, g1, v1} = 6'b101_001;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask

  task automatic do_reset();
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    check("rst_phase", 32'(phase), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_flashing", 32'(flashing), 0);
    check("rst_err", 32'(err), 0);
    check("rst_code", 32'(err_code), 0);
    check("rst_cycles", 32'(cycles), 0);

    // three normal cycles
    for (int rep = 0; rep < 3; rep++) begin
      step(1);
      check("cyc_locked", 32'(locked), 1);
      check("cyc_count", 32'(cycles), 32'(rep));
      check("cyc_phase_a", 32'(phase), 1);
      steps(1, 4);
      step(2);
      check("cyc_phase_ay", 32'(phase), 2);
      steps(3, 5);
      check("cyc_phase_b", 32'(phase), 3);
      step(4);
      check("cyc_phase_by", 32'(phase), 4);
    end
    check("cyc_err", 32'(err), 0);
    check("cyc_final", 32'(cycles), 2);

    // short green
    steps(1, 2);
    check("short_pre_err", 32'(err), 0);
    step(2);
    check("short_err", 32'(err), 1);
    check("short_code", 32'(err_code), 3);
    check("short_locked", 32'(locked), 0);
    do_reset();
    check("rst2_err", 32'(err), 0);
    check("rst2_code", 32'(err_code), 0);
    check("rst2_phase", 32'(phase), 0);
    check("rst2_cycles", 32'(cycles), 0);
    check("rst2_locked", 32'(locked), 0);

    // green timeout at the 9th sample
    steps(1, 3); step(2); steps(3, 8);
    check("tmo_pre_err", 32'(err), 0);
    step(3);
    check("tmo_err", 32'(err), 1);
    check("tmo_code", 32'(err_code), 4);
    do_reset();

    // bad successor
    steps(1, 5); step(3);
    check("succ_code", 32'(err_code), 2);
    do_reset();

    // long yellow
    steps(1, 3); step(2); step(2);
    check("yel_long_code", 32'(err_code), 4);
    do_reset();

    // long flash half straight after lock
    step(5);
    check("fl_lock_flashing", 32'(flashing), 1);
    step(5);
    check("fl_long_code", 32'(err_code), 4);
    do_reset();

    // flash run from RUN and back
    steps(1, 5);
    for (int i = 0; i < 20; i++) begin
      step((i % 2 == 0) ? 5 : 6);
      if (i == 0 || i == 19) begin
        check("fl_flashing", 32'(flashing), 1);
        check("fl_locked", 32'(locked), 1);
      end
    end
    step(1);
    check("fl_exit_flashing", 32'(flashing), 0);
    check("fl_exit_locked", 32'(locked), 1);
    steps(1, 4); step(2);
    check("fl_after_err", 32'(err), 0);
    check("fl_after_phase", 32'(phase), 2);
    check("fl_after_locked", 32'(locked), 1);
    do_reset();

    // illegal pattern, then sticky code
    steps(1, 5); step(2); steps(3, 3); step(7);
    check("ill_phase", 32'(phase), 7);
    check("ill_code", 32'(err_code), 1);
    steps(1, 2); step(3);
    check("ill_sticky_code", 32'(err_code), 1);
    check("ill_sticky_err", 32'(err), 1);
    check("ill_live_phase", 32'(phase), 3);
    do_reset();

    // SYNC ignores junk, then first P_A segment is not min-checked
    step(7); step(3); step(4);
    check("sync_locked", 32'(locked), 0);
    check("sync_err", 32'(err), 0);
    step(1);
    check("sync_lock_a", 32'(locked), 1);
    steps(1, 2); step(2);
    check("sync_first_err", 32'(err), 0);
    do_reset();

    // first segment shorter than GREEN_MIN is allowed
    step(1); step(2);
    check("first_short_err", 32'(err), 0);
    check("first_short_locked", 32'(locked), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
